// File: rtl/led_blink_multi_if.sv
// Configuration/sync bus and LED/tick outputs of the multi-channel blinker.
// The host drives the master side; the blinker sits on the slave side.
interface led_blink_multi_if #(
    parameter int CHANNELS = 4,
    parameter int HALF_W   = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                CFG_WE;
    logic [CH_W-1:0]     CFG_CH;
    logic [1:0]          CFG_MODE;
    logic [HALF_W-1:0]   CFG_HALF;
    logic                SYNC;
    logic                TICK;
    logic [CHANNELS-1:0] LED;

    modport master (
        output CFG_WE, CFG_CH, CFG_MODE, CFG_HALF, SYNC,
        input  TICK, LED
    );

    modport slave (
        input  CFG_WE, CFG_CH, CFG_MODE, CFG_HALF, SYNC,
        output TICK, LED
    );
endinterface

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: shared tick prescaler, per-channel
// off/on/blink/pulse mode and run-time half-period.
module led_blink_multi #(
    parameter int SYS_CLK  = 100000000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 4,
    parameter int HALF_W   = 16,
    parameter int DEF_HALF = 500
) (
    input logic              CLK,
    input logic              RESETBTN,
    led_blink_multi_if.slave bus
);
    localparam int DIV   = SYS_CLK / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(DIV - 1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;

    if (DIV < 2) begin : g_bad_div
        $error("SYS_CLK/TICK_HZ must be at least 2");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
        $error("CHANNELS must be in 1..16");
    end

    logic                           run_q;
    logic [DIV_W-1:0]               pre_q, pre_d;
    logic                           tick_q, tick_d;
    logic                           tk;
    logic [CHANNELS-1:0][1:0]       mode_q, mode_d;
    logic [CHANNELS-1:0][HALF_W-1:0] half_q, half_d;
    logic [CHANNELS-1:0][HALF_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            phase_q, phase_d;
    logic [CHANNELS-1:0]            led_q, led_d;
    logic [CHANNELS-1:0]            wrap;

    // Release flop: logic starts counting on the second edge after deassert
    always_ff @(posedge CLK or negedge RESETBTN) begin
        if (!RESETBTN) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETBTN) begin
        if (!RESETBTN) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            mode_q  <= {CHANNELS{M_BLINK}};
            half_q  <= {CHANNELS{HALF_W'(DEF_HALF)}};
            cnt_q   <= '0;
            phase_q <= '0;
            led_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    // half of zero behaves as one, so the last count is zero in both cases
    always_comb begin
        wrap = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (half_q[i] == '0) begin
                wrap[i] = (cnt_q[i] == '0);
            end else begin
                wrap[i] = (cnt_q[i] == half_q[i] - HALF_W'(1));
            end
        end
    end

    always_comb begin
        pre_d   = pre_q;
        tick_d  = 1'b0;
        tk      = 1'b0;
        mode_d  = mode_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        led_d   = led_q;
        if (run_q) begin
            if (bus.SYNC) begin
                pre_d = '0;
            end else if (pre_q == PRE_MAX) begin
                pre_d = '0;
                tk    = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
            tick_d = tk;
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.CFG_WE && bus.CFG_CH == CH_W'(i)) begin
                    mode_d[i]  = bus.CFG_MODE;
                    half_d[i]  = bus.CFG_HALF;
                    cnt_d[i]   = '0;
                    phase_d[i] = 1'b0;
                    led_d[i]   = (bus.CFG_MODE == M_ON);
                end else if (bus.SYNC || !mode_q[i][1]) begin
                    cnt_d[i]   = '0;
                    phase_d[i] = 1'b0;
                    led_d[i]   = (mode_q[i] == M_ON);
                end else if (tk) begin
                    cnt_d[i]   = wrap[i] ? '0 : cnt_q[i] + 1'b1;
                    phase_d[i] = phase_q[i] ^ wrap[i];
                    // pulse fires on the 1->0 phase toggle only
                    if (mode_q[i] == M_BLINK) begin
                        led_d[i] = phase_q[i] ^ wrap[i];
                    end else begin
                        led_d[i] = wrap[i] & phase_q[i];
                    end
                end
            end
        end
    end

    assign bus.TICK = tick_q;
    assign bus.LED  = led_q;

    logic unused_off;
    assign unused_off = (M_OFF == 2'd0);
endmodule

// File: tb/tb_led_blink_multi.sv
// Randomised bench for led_blink_multi against a tick-count
// reference model of the blink/pulse waveforms.
module tb_led_blink_multi;
    localparam int DIV  = 10;
    localparam int NCH  = 4;
    localparam int DEFH = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_blink_multi_if #(.CHANNELS(NCH), .HALF_W(8)) bus ();

    led_blink_multi #(
        .SYS_CLK (20),
        .TICK_HZ (2),
        .CHANNELS(NCH),
        .HALF_W  (8),
        .DEF_HALF(DEFH)
    ) dut (
        .CLK     (clk),
        .RESETBTN(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit rel;
    int pcount;
    bit tick_m;
    int mode_m [NCH];
    int half_m [NCH];
    int k_m    [NCH];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rel    = 1'b0;
        pcount = 0;
        tick_m = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            mode_m[c] = 2;
            half_m[c] = DEFH;
            k_m[c]    = 0;
        end
    endfunction

    // LED as a function of ticks elapsed since the channel last restarted
    function automatic logic [NCH-1:0] led_model();
        logic [NCH-1:0] v;
        int e;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            e = (half_m[c] == 0) ? 1 : half_m[c];
            case (mode_m[c])
                0: v[c] = 1'b0;
                1: v[c] = 1'b1;
                2: v[c] = ((k_m[c] / e) % 2) == 1;
                default: v[c] = (k_m[c] > 0) && (k_m[c] % (2 * e) == 0);
            endcase
        end
        return v;
    endfunction

    function automatic void model_edge();
        bit tk;
        if (!rel) begin
            rel    = 1'b1;
            tick_m = 1'b0;
            return;
        end
        tk = 1'b0;
        if (bus.SYNC) begin
            pcount = 0;
        end else begin
            tk = (pcount % DIV) == DIV - 1;
            pcount++;
        end
        tick_m = tk;
        for (int c = 0; c < NCH; c++) begin
            if (bus.CFG_WE && int'(bus.CFG_CH) == c) begin
                mode_m[c] = int'(bus.CFG_MODE);
                half_m[c] = int'(bus.CFG_HALF);
                k_m[c]    = 0;
            end else if (bus.SYNC) begin
                k_m[c] = 0;
            end else if (tk && mode_m[c] >= 2) begin
                k_m[c]++;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check("tick", bus.TICK, tick_m);
        check("led", bus.LED, led_model());
        @(negedge clk);
    endtask

    task automatic cfg(int ch, int mode, int half);
        bus.CFG_WE   = 1'b1;
        bus.CFG_CH   = 2'(ch);
        bus.CFG_MODE = 2'(mode);
        bus.CFG_HALF = 8'(half);
        step();
        bus.CFG_WE = 1'b0;
    endtask

    // advance until the next edge is a tick edge
    task automatic to_tick();
        for (int n = 0; n < DIV + 2; n++) begin
            if (rel && (pcount % DIV) == DIV - 1) break;
            step();
        end
    endtask

    initial begin
        bus.CFG_WE   = 1'b0;
        bus.CFG_CH   = '0;
        bus.CFG_MODE = '0;
        bus.CFG_HALF = '0;
        bus.SYNC     = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_led0", bus.LED, 0);
        check("rst_tick0", bus.TICK, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (100) step();

        cfg(1, 3, 2);
        repeat (100) step();

        cfg(2, 0, 3);
        cfg(3, 1, 3);
        cfg(0, 2, 0);
        repeat (40) step();

        to_tick();
        cfg(0, 2, 3);
        repeat (35) step();

        repeat (4) step();
        bus.SYNC = 1'b1;
        step();
        bus.SYNC = 1'b0;
        repeat (60) step();

        to_tick();
        bus.SYNC = 1'b1;
        step();
        bus.SYNC = 1'b0;
        repeat (30) step();

        bus.SYNC = 1'b1;
        cfg(2, 2, 1);
        bus.SYNC = 1'b0;
        repeat (30) step();

        for (int n = 0; n < 800; n++) begin
            bus.CFG_WE   = ($urandom_range(0, 19) == 0);
            bus.CFG_CH   = 2'($urandom_range(0, NCH - 1));
            bus.CFG_MODE = 2'($urandom_range(0, 3));
            bus.CFG_HALF = 8'($urandom_range(0, 5));
            bus.SYNC     = ($urandom_range(0, 49) == 0);
            step();
        end
        bus.CFG_WE = 1'b0;
        bus.SYNC   = 1'b0;

        for (int c = 0; c < NCH; c++) cfg(c, 1, 3);
        to_tick();
        step();
        check("pre_rst_tick", bus.TICK, tick_m);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_led", bus.LED, 0);
        check("async_tick", bus.TICK, 0);
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (120) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
